pipe_data_mem_ws: RTL and testbench

- Parametrised successor to the pipeline's single-cycle data memory.
- Word-organised RAM with configurable depth and byte-lane write enables.
- Programmable wait-state count, with a req/busy/ready handshake so the pipeline can stall on slow memory.
- Sits between the MEM stage (integer and FPU load/store) and the stall logic.

---
 rtl/pipe_data_mem_ws.sv | 127 ++++++++++++
 tb/tb_pipe_data_mem_ws.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_data_mem_ws.sv
// Word-organised data memory with byte-lane writes and a programmable wait-state count.
// Latency: ready pulses WAIT_STATES+1 edges after the accept edge; busy covers the whole access.
// Backpressure: req is accepted only while busy=0; optional error reporting under DMEM_ERR_EN.
module pipe_data_mem_ws #(
  parameter int AW          = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic        mem_clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        busy,
  output logic        ready
`ifdef DMEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   din_q;
  logic          bad_q;
  logic          bad_d;
  logic [31:0]   dataout_q;
  logic          ready_q;
  logic [31:0]   ram_q [DEPTH];
  logic          done;
  logic          wr_fire;

`ifdef DMEM_ERR_EN
  logic          err_q;

  // A partial-lane write at a misaligned address, or any address beyond the array, is an error.
  assign bad_d = ((addr[1:0] != 2'b00) && we && (be != 4'hF)) || (addr[31:AW+2] != '0);
  assign err   = err_q;
`else
  logic          unused_addr_bits;

  // Without error checking the low bits are dropped and high bits simply alias.
  assign bad_d            = 1'b0;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

  assign done    = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_fire = done && we_q && !bad_q;
  assign busy    = (state_q == BUSY);
  assign ready   = ready_q;
  assign dataout = dataout_q;

  // Access FSM: latch request in IDLE, count wait states in BUSY, complete when the count is exhausted.
  always_ff @(posedge mem_clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      idx_q     <= '0;
      din_q     <= 32'h0;
      bad_q     <= 1'b0;
      dataout_q <= 32'h0;
      ready_q   <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            be_q    <= be;
            idx_q   <= addr[AW+1:2];
            din_q   <= datain;
            bad_q   <= bad_d;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ready_q <= 1'b1;
`ifdef DMEM_ERR_EN
            err_q   <= bad_q;
`endif
            if (!we_q) begin
              dataout_q <= bad_q ? 32'h0 : ram_q[idx_q];
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array write happens only on the completion edge, so an access cut short by reset never lands.
  always_ff @(posedge mem_clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          ram_q[idx_q][8*i +: 8] <= din_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_data_mem_ws.sv
// Bench for pipe_data_mem_ws: two instances (0 and 3 wait states) against an array-based reference.
// Directed scenarios followed by random accesses; every check is an immediate assertion.
// Build with DMEM_ERR_EN defined to also exercise the error output.
module tb_pipe_data_mem_ws;

  logic        clk;
  logic        clrn   [2];
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] din    [2];
  logic [31:0] dout   [2];
  logic        busy   [2];
  logic        ready  [2];
`ifdef DMEM_ERR_EN
  logic        err    [2];
`endif

  logic [31:0] mdl    [2][32];
  logic [31:0] mdout  [2];
  int          nassert;
  int          nfail;

  pipe_data_mem_ws #(.AW(5), .WAIT_STATES(0)) u_ws0 (
    .mem_clk (clk),
    .clrn    (clrn[0]),
    .req     (req[0]),
    .we      (we[0]),
    .be      (be[0]),
    .addr    (addr[0]),
    .datain  (din[0]),
    .dataout (dout[0]),
    .busy    (busy[0]),
    .ready   (ready[0])
`ifdef DMEM_ERR_EN
    ,
    .err     (err[0])
`endif
  );

  pipe_data_mem_ws #(.AW(5), .WAIT_STATES(3)) u_ws3 (
    .mem_clk (clk),
    .clrn    (clrn[1]),
    .req     (req[1]),
    .we      (we[1]),
    .be      (be[1]),
    .addr    (addr[1]),
    .datain  (din[1]),
    .dataout (dout[1]),
    .busy    (busy[1]),
    .ready   (ready[1])
`ifdef DMEM_ERR_EN
    ,
    .err     (err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_err(input int k, input logic exp);
`ifdef DMEM_ERR_EN
    chk("err", {31'h0, err[k]}, {31'h0, exp});
`else
    if (k < 0 || exp === 1'bx) chk("err_unreachable", 32'h0, 32'h1);
`endif
  endtask

  // While the instance is busy, throw garbage at every input; none of it may matter.
  task automatic scramble(input int k);
    req[k]  = 1'($urandom_range(0, 1));
    we[k]   = 1'($urandom_range(0, 1));
    be[k]   = 4'($urandom);
    addr[k] = $urandom;
    din[k]  = $urandom;
  endtask

  // One full access, entered and left at #1 after a rising edge with req low on exit.
  task automatic access(input int k, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    int ws;
    int idx;
    bit bad;
    ws  = (k == 0) ? 0 : 3;
    idx = int'(a[6:2]);
    bad = 1'b0;
`ifdef DMEM_ERR_EN
    bad = ((a[1:0] != 2'b00) && w && (b != 4'hF)) || (a[31:7] != 25'h0);
`endif
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; din[k] = d;
    @(posedge clk); #1;
    chk("busy_after_accept", {31'h0, busy[k]}, 32'h1);
    chk("ready_after_accept", {31'h0, ready[k]}, 32'h0);
    scramble(k);
    for (int c = 1; c <= ws; c++) begin
      @(posedge clk); #1;
      chk("busy_wait", {31'h0, busy[k]}, 32'h1);
      chk("ready_wait", {31'h0, ready[k]}, 32'h0);
      scramble(k);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        mdout[k] = mdl[k][idx];
      end
    end else if (!w) begin
      mdout[k] = 32'h0;
    end
    chk("ready_pulse", {31'h0, ready[k]}, 32'h1);
    chk("busy_done", {31'h0, busy[k]}, 32'h0);
    chk("dataout", dout[k], mdout[k]);
    chk_err(k, bad);
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'h0, ready[k]}, 32'h0);
    chk("idle_after", {31'h0, busy[k]}, 32'h0);
    chk_err(k, 1'b0);
  endtask

  initial begin
    nassert = 0;
    nfail   = 0;
    for (int k = 0; k < 2; k++) begin
      clrn[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
      addr[k] = 32'h0; din[k] = 32'h0; mdout[k] = 32'h0;
      for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
    end

    // Reset values.
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", {31'h0, busy[k]}, 32'h0);
      chk("rst_ready", {31'h0, ready[k]}, 32'h0);
      chk("rst_dataout", dout[k], 32'h0);
      chk_err(k, 1'b0);
    end
    @(posedge clk); #1;
    clrn[0] = 1'b1; clrn[1] = 1'b1;

    // Bring every word to a known zero through the normal write path.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) access(k, 1'b1, 4'hF, 32'(i * 4), 32'h0);

    // Basic write/read, zero wait states.
    access(0, 1'b1, 4'hF, 32'h00, 32'hBF800000);
    access(0, 1'b0, 4'hF, 32'h00, 32'h0);
    chk("ws0_read", dout[0], 32'hBF800000);

    // Three wait states.
    access(1, 1'b1, 4'hF, 32'h50, 32'h40C00000);
    access(1, 1'b0, 4'h0, 32'h50, 32'h0);
    chk("ws3_read", dout[1], 32'h40C00000);

    // Byte lanes and the empty-mask write.
    access(0, 1'b1, 4'hF, 32'h0C, 32'h41100000);
    access(0, 1'b1, 4'b0001, 32'h0C, 32'h000000AB);
    access(0, 1'b0, 4'hF, 32'h0C, 32'h0);
    chk("lane_merge", dout[0], 32'h411000AB);
    access(0, 1'b1, 4'b0000, 32'h0C, 32'hFFFFFFFF);
    access(0, 1'b0, 4'hF, 32'h0C, 32'h0);
    chk("lane_none", dout[0], 32'h411000AB);

    // req held through the ready cycle is taken as a fresh access on the next edge.
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h0C; din[0] = 32'h0;
    @(posedge clk); #1;
    chk("held_busy1", {31'h0, busy[0]}, 32'h1);
    @(posedge clk); #1;
    chk("held_ready1", {31'h0, ready[0]}, 32'h1);
    chk("held_data1", dout[0], 32'h411000AB);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("held_busy2", {31'h0, busy[0]}, 32'h1);
    chk("held_ready2", {31'h0, ready[0]}, 32'h0);
    @(posedge clk); #1;
    chk("held_ready3", {31'h0, ready[0]}, 32'h1);
    mdout[0] = 32'h411000AB;
    @(posedge clk); #1;

    // Aliasing past the array depth (an error when range checking is built in).
    access(0, 1'b1, 4'hF, 32'h5C, 32'h47C00000);
    access(0, 1'b0, 4'hF, 32'hDC, 32'h0);

    // Reset in the middle of a slow write: the write must never land.
    access(1, 1'b0, 4'hF, 32'h04, 32'h0);
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h04; din[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    clrn[1] = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy[1]}, 32'h0);
    chk("arst_ready", {31'h0, ready[1]}, 32'h0);
    chk("arst_dataout", dout[1], 32'h0);
    mdout[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    clrn[1] = 1'b1;
    access(1, 1'b0, 4'hF, 32'h04, 32'h0);
    chk("arst_no_write", dout[1], mdl[1][1]);

    // Misaligned partial write, then an aligned in-range read of the same word.
    access(0, 1'b1, 4'b0011, 32'h102, 32'h12345678);
    access(0, 1'b0, 4'hF, 32'h100, 32'h0);
    access(0, 1'b0, 4'hF, 32'h00, 32'h0);

    // Random traffic on both instances.
    for (int n = 0; n < 80; n++) begin
      int          k;
      logic [31:0] a;
      k = n % 2;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      access(k, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
